// File: rtl/wb_slave_regbank.sv
// Wishbone pipelined slave register bank: NUM_REGS RW control words, a live
// STATUS word, a W1C EVENT latch, an interrupt MASK and a registered irq.
module wb_slave_regbank #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cyc,
  input  logic                           stb,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        sel,
  output logic                           stall,
  output logic                           ack,
  output logic                           err,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [DATA_WIDTH-1:0]          status_i,
  input  logic [DATA_WIDTH-1:0]          event_i,
  output logic                           irq_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned IW = ADDR_WIDTH - 2;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] event_q, event_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] bm;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] clr;
  logic                  hit_ctrl, hit_status, hit_event, hit_mask;
  logic                  valid, accept, wr;

  assign idx        = addr[ADDR_WIDTH-1:2];
  assign hit_ctrl   = idx < IW'(NUM_REGS);
  assign hit_status = idx == IW'(NUM_REGS);
  assign hit_event  = idx == IW'(NUM_REGS + 1);
  assign hit_mask   = idx == IW'(NUM_REGS + 2);
  assign valid      = (addr[1:0] == 2'b00)
                    && (hit_ctrl || hit_status || hit_event || hit_mask)
                    && !(we && hit_status);
  assign accept     = (state_q == IDLE) && cyc && stb;
  assign wr         = accept && valid && we;

  always_comb begin
    bm = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bm[i*8 +: 8] = {8{sel[i]}};
    end
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (idx == IW'(k)) rd_val = ctrl_q[k];
    end
    if (hit_status) rd_val = status_i;
    if (hit_event)  rd_val = event_q;
    if (hit_mask)   rd_val = mask_q;
  end

  // Incoming event pulses win over a same-edge W1C of the same bit.
  assign clr = (wr && hit_event) ? (wdata & bm) : '0;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      ctrl_d[k] = ctrl_q[k];
      if (wr && hit_ctrl && (idx == IW'(k))) begin
        ctrl_d[k] = (ctrl_q[k] & ~bm) | (wdata & bm);
      end
    end
    mask_d  = (wr && hit_mask) ? ((mask_q & ~bm) | (wdata & bm)) : mask_q;
    event_d = (event_q & ~clr) | event_i;
    irq_d   = |(event_d & mask_d);
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          ack_d   = valid;
          err_d   = !valid;
          rdata_d = (valid && !we) ? rd_val : '0;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      event_q <= '0;
      mask_q  <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      event_q <= event_d;
      mask_q  <= mask_d;
      for (int unsigned k = 0; k < NUM_REGS; k++) ctrl_q[k] <= ctrl_d[k];
    end
  end

  // Termination is suppressed if the master abandons the cycle or reset hits mid-response.
  assign stall = (state_q == RESP);
  assign ack   = ack_q && cyc && !rst;
  assign err   = err_q && cyc && !rst;
  assign rdata = rdata_q;
  assign irq_o = irq_q;

  always_comb begin
    regs_o = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
    end
  end

endmodule

// File: tb/tb_wb_slave_regbank.sv
// Directed vector bench for wb_slave_regbank (NUM_REGS=8, 32-bit bus).
module tb_wb_slave_regbank;

  logic         clk = 1'b0;
  logic         rst, cyc, stb, we;
  logic [31:0]  addr, wdata, status_i, event_i;
  logic [3:0]   sel;
  logic         stall, ack, err, irq_o;
  logic [31:0]  rdata;
  logic [255:0] regs_o;

  int nvec = 0;
  int nmis = 0;

  wb_slave_regbank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .addr(addr),
    .wdata(wdata), .sel(sel), .stall(stall), .ack(ack), .err(err),
    .rdata(rdata), .regs_o(regs_o), .status_i(status_i), .event_i(event_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] st;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ev,
                        output logic o_ack, output logic o_err, output logic o_stall,
                        output logic o_irq, output logic [31:0] o_rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s; event_i = ev;
    @(posedge clk);
    #1;
    o_ack = ack; o_err = err; o_stall = stall; o_irq = irq_o; o_rd = rdata;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; event_i = '0;
  endtask

  logic        r_ack, r_err, r_stall, r_irq;
  logic [31:0] r_rd;

  initial begin
    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h00, 32'h11223344, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h00, 32'hAABBCCDD, 4'h5, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0, 1'b1, 1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h1C, 32'h12345678, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h1C, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h20, 32'h0,        4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'h0BADF00D};
    vecs[8]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0BADF00D, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h02, 32'h0,        4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h2C, 32'h0,        4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'h2C, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h05, 32'h00000000, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h04, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0, 32'hFFFFFFFF};
    vecs[15] = '{1'b0, 32'h24, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 32'h28, 32'h000012F0, 4'h1, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h28, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0, 32'h000000F0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; status_i = '0; event_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_ack",   {31'b0, ack},   32'h0);
    check("rst_err",   {31'b0, err},   32'h0);
    check("rst_rdata", rdata,          32'h0);
    check("rst_irq",   {31'b0, irq_o}, 32'h0);
    check("rst_regs",  {31'b0, |regs_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      status_i = vecs[i].st;
      access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 32'h0,
             r_ack, r_err, r_stall, r_irq, r_rd);
      check($sformatf("v%0d_ack", i),   {31'b0, r_ack},   {31'b0, vecs[i].e_ack});
      check($sformatf("v%0d_err", i),   {31'b0, r_err},   {31'b0, vecs[i].e_err});
      check($sformatf("v%0d_stall", i), {31'b0, r_stall}, 32'h1);
      check($sformatf("v%0d_rdata", i), r_rd,             vecs[i].e_rd);
    end

    @(posedge clk); #1;
    check("idle_rdata_hold", rdata, 32'h000000F0);
    check("idle_ack",   {31'b0, ack},   32'h0);
    check("idle_stall", {31'b0, stall}, 32'h0);
    check("regs_ctrl0", regs_o[31:0],    32'h11BB33DD);
    check("regs_ctrl1", regs_o[63:32],   32'hFFFFFFFF);
    check("regs_ctrl2", regs_o[95:64],   32'hDEADBEEF);
    check("regs_ctrl7", regs_o[255:224], 32'h0);
    check("irq_masked_off", {31'b0, irq_o}, 32'h0);

    // Event latch, mask and W1C race
    @(negedge clk); event_i = 32'h5;
    @(negedge clk); event_i = 32'h0;
    check("irq_event_unmasked", {31'b0, irq_o}, 32'h0);
    access(1'b1, 32'h28, 32'h4, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("mask_wr_irq", {31'b0, r_irq}, 32'h1);
    access(1'b1, 32'h24, 32'h4, 4'hF, 32'h4, r_ack, r_err, r_stall, r_irq, r_rd);
    check("w1c_race_ack", {31'b0, r_ack}, 32'h1);
    check("w1c_race_irq", {31'b0, r_irq}, 32'h1);
    access(1'b0, 32'h24, 32'h0, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("w1c_race_event", r_rd, 32'h5);
    access(1'b1, 32'h24, 32'h4, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("w1c_irq", {31'b0, r_irq}, 32'h0);
    access(1'b0, 32'h24, 32'h0, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("w1c_event", r_rd, 32'h1);
    access(1'b1, 32'h24, 32'h1, 4'h0, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    access(1'b0, 32'h24, 32'h0, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("w1c_sel0_event", r_rd, 32'h1);

    // Back-to-back STATUS reads with cyc/stb held
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h20; status_i = 32'hCAFE0001;
    check("b2b_ack_pre", {31'b0, ack}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ack%0d", i), {31'b0, ack}, {31'b0, (i % 2) == 0});
      if ((i % 2) == 0) check($sformatf("b2b_rdata%0d", i), rdata, 32'hCAFE0001);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;

    // cyc dropped during RESP: valid write, then invalid access
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; wdata = 32'h55; sel = 4'hF;
      addr = (i == 0) ? 32'h0C : 32'h0D;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      #1;
      check($sformatf("drop%0d_ack", i),   {31'b0, ack},   32'h0);
      check($sformatf("drop%0d_err", i),   {31'b0, err},   32'h0);
      check($sformatf("drop%0d_stall", i), {31'b0, stall}, 32'h1);
      @(posedge clk); #1;
      check($sformatf("drop%0d_idle", i),  {31'b0, stall}, 32'h0);
      we = 1'b0;
    end
    check("drop_commit", regs_o[127:96], 32'h55);
    access(1'b0, 32'h0C, 32'h0, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("drop_readback", r_rd, 32'h55);
    access(1'b1, 32'h28, 32'h1, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("pre_rst_irq", {31'b0, r_irq}, 32'h1);

    // Reset asserted during RESP
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h77; sel = 4'hF;
    @(posedge clk); #1;
    check("rr_ack_before", {31'b0, ack}, 32'h1);
    rst = 1'b1;
    #1;
    check("rr_ack_abort", {31'b0, ack}, 32'h0);
    @(posedge clk); #1;
    check("rr_stall", {31'b0, stall}, 32'h0);
    check("rr_ack",   {31'b0, ack},   32'h0);
    check("rr_err",   {31'b0, err},   32'h0);
    check("rr_rdata", rdata,          32'h0);
    check("rr_irq",   {31'b0, irq_o}, 32'h0);
    check("rr_regs",  {31'b0, |regs_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    access(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, r_ack, r_err, r_stall, r_irq, r_rd);
    check("post_rst_ack",   {31'b0, r_ack}, 32'h1);
    check("post_rst_ctrl4", r_rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/wb_slave_regbank.md
WB_SLAVE_REGBANK -- requirements
Module: wb_slave_regbank

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: Wishbone byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32: Wishbone data width, a multiple of 8.
REQ-003 Parameter NUM_REGS, default 8: number of read/write control registers; range 1..64.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cyc, stb, we  input  1 each  Wishbone master cycle, strobe and write-enable.
REQ-007 addr  input  ADDR_WIDTH  byte address; word index = addr[ADDR_WIDTH-1:2].
REQ-008 wdata  input  DATA_WIDTH  write data.
REQ-009 sel  input  DATA_WIDTH/8  byte lane enables.
REQ-010 stall, ack, err  output  1 each  slave stall, normal termination, error termination.
REQ-011 rdata  output  DATA_WIDTH  read data, valid while ack=1.
REQ-012 regs_o  output  NUM_REGS*DATA_WIDTH  flattened control registers, register k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 status_i  input  DATA_WIDTH  live status word, read-only.
REQ-014 event_i  input  DATA_WIDTH  per-bit single-cycle event pulses.
REQ-015 irq_o  output  1  interrupt, registered.

Function
REQ-016 Word map: index 0..NUM_REGS-1 = CTRL[k] (RW); NUM_REGS = STATUS (RO, returns status_i); NUM_REGS+1 = EVENT (W1C); NUM_REGS+2 = MASK (RW).
REQ-017 The FSM has two states, IDLE and RESP; stall=0 in IDLE and stall=1 in RESP.
REQ-018 A request is accepted in IDLE on a rising edge with cyc=1 and stb=1; the FSM then moves to RESP.
REQ-019 RESP lasts exactly one cycle and always returns to IDLE; at most one access per 2 cycles.
REQ-020 In RESP, ack=1 for a valid access and err=1 for an invalid one; never both; both 0 in IDLE.
REQ-021 ack and err are gated by cyc: if cyc=0 during RESP, both stay 0 and the FSM still returns to IDLE with no further effect.
REQ-022 Invalid access means addr[1:0]!=0, word index > NUM_REGS+2, or a write to STATUS; an invalid access has no register side effect.
REQ-023 Writes to CTRL and MASK commit at the accepting edge, byte lane i updated only when sel[i]=1; sel=0 is a valid no-op write (ack).
REQ-024 A write to EVENT clears each bit whose wdata bit and sel lane are both 1; a write never sets EVENT bits.
REQ-025 EVENT bit n is set on every edge where event_i[n]=1; a set and a clear of the same bit on the same edge leaves the bit set.
REQ-026 Reads are side-effect free; rdata is registered at the accepting edge, ignores sel, and shows the value held before that edge.
REQ-027 rdata is 0 on writes and on err; rdata holds its value when ack=0.
REQ-028 irq_o is registered: irq_o(t+1) = |(EVENT(t+1) & MASK(t+1)), so it is 1 cycle after the edge that changes EVENT or MASK.
REQ-029 regs_o reflects CTRL directly, with no added latency after the commit edge.

Reset
REQ-030 rst=1 at a rising edge forces FSM=IDLE and stall, ack, err, rdata, irq_o, all CTRL, EVENT and MASK to 0, overriding any concurrent access or event.
REQ-031 Reset asserted while in RESP aborts the response: no ack or err is issued, and the in-flight write has already committed only if its accepting edge preceded reset.

Verification
REQ-032 Write CTRL[2]=0xDEADBEEF, sel=4'hF, then read index 2 -> ack 1 cycle after acceptance, stall high that cycle, rdata=0xDEADBEEF, regs_o[95:64]=0xDEADBEEF.
REQ-033 CTRL[0]=0x11223344, then write 0xAABBCCDD with sel=4'b0101 -> readback 0x11BB33DD.
REQ-034 Pulse event_i=0x5; MASK=0x4 -> irq_o=1; write EVENT 0x4 on the same edge event_i[2] pulses again -> EVENT stays 0x5, irq_o stays 1; next W1C 0x4 with no pulse -> EVENT=0x1, irq_o=0.
REQ-035 Access addr=0x2, index NUM_REGS+3, and a write to STATUS -> err=1, ack=0, rdata=0, no register changes.
REQ-036 Drop cyc during RESP -> no ack or err; also assert rst during RESP -> all outputs 0 next cycle, FSM IDLE.
REQ-037 Hold cyc=stb=1 for 4 reads of STATUS with status_i=0xCAFE0001 -> ack pattern 0,1,0,1, each read returns 0xCAFE0001.
